regfile_operand_stage: RTL
==========================

Name: regfile_operand_stage

Overview:
- Sits directly downstream of the two 64-bit 32:1 register-file read muxes.
- Takes the raw read-port data and applies XZR zeroing and same-cycle write-back bypass.
- Registers both operands into the ID/EX boundary with valid/stall/flush control.
- While stalled, keeps the held operands coherent with later write-backs, so EX never consumes a stale register value.

Parameters:
- WIDTH, 64, operand/register data width
- NREG, 32, number of architectural registers
- AW, 5, register address width ($clog2(NREG))
- ZERO_REG, 31, register index that always reads 0 (XZR)

Ports:
- clk  input  1  single clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ID stage presents a valid instruction this cycle
- rs1_addr  input  AW  read address for port 1 (same address driving read mux 1)
- rs2_addr  input  AW  read address for port 2
- rd_data1  input  WIDTH  output of read mux 1
- rd_data2  input  WIDTH  output of read mux 2
- wb_en  input  1  write-back write enable this cycle
- wb_addr  input  AW  write-back destination register
- wb_data  input  WIDTH  write-back data
- stall  input  1  hazard unit: hold ID/EX contents
- flush  input  1  branch/exception: kill ID/EX contents
- op_a  output  WIDTH  registered operand 1 to EX
- op_b  output  WIDTH  registered operand 2 to EX
- op_a_addr  output  AW  registered rs1 (for EX forwarding unit)
- op_b_addr  output  AW  registered rs2
- out_valid  output  1  ID/EX slot holds a live instruction

Behaviour:
- Reset (reset_n=0, asynchronous): op_a=0, op_b=0, op_a_addr=0, op_b_addr=0, out_valid=0. Reset is asserted asynchronously and released synchronously to clk.
- Combinational operand select, per port n (evaluated in priority order):
  - rsn_addr==ZERO_REG gives 0.
  - Otherwise, wb_en && wb_addr==rsn_addr gives wb_data (bypass of the register file's write-before-read gap).
  - Otherwise, rd_datan.
- Registered update priority at each clk edge: flush > stall > load.
- flush=1: out_valid<=0, op_a/op_b<=0, addrs<=0. This holds regardless of stall or in_valid.
- stall=1, flush=0: out_valid and addrs hold. For each held operand, if wb_en && wb_addr==op_x_addr && op_x_addr!=ZERO_REG && out_valid, then op_x<=wb_data; otherwise op_x holds.
- Neither asserted: op_a/op_b <= selected values, addrs <= rs addrs, out_valid<=in_valid. Data is captured even when in_valid=0; EX must gate on out_valid.
- Latency: exactly 1 cycle from rs/rd_data presentation to op_a/op_b.
- Both ports may match wb_addr simultaneously; both get wb_data.
- XZR is never bypassed or refreshed, on either path.
- Reset mid-stall: all state clears immediately; the refresh logic must not revive out_valid.
- No X propagation: with in_valid=0, all outputs stay defined from defined inputs.

Decomposition:
- Shared package (regfile_pkg):
  - localparams WIDTH=64, NREG=32, AW=5, ZERO_REG=31
  - typedef logic [WIDTH-1:0] reg_data_t
  - typedef logic [AW-1:0] reg_addr_t
- Sub-module operand_bypass (combinational, one instance per port):
  - Inputs: rs_addr, rd_data, wb_en, wb_addr, wb_data.
  - Output: the selected operand.
- The top level holds the ID/EX flops, the stall-refresh comparators and the flush/stall priority logic.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with out_valid=1 and op_a=0xDEAD -> all outputs 0 immediately, before the next clk edge.
- Plain load: in_valid=1, rs1=3, rs2=7, rd_data1=0x11, rd_data2=0x22, wb_en=0 -> next cycle op_a=0x11, op_b=0x22, op_a_addr=3, op_b_addr=7, out_valid=1.
- XZR and bypass:
  - rs1=31 with rd_data1=0xFFFF -> op_a=0.
  - rs2=5 with wb_en=1, wb_addr=5, wb_data=0xABCD, rd_data2=0x1 -> op_b=0xABCD.
  - wb_addr=31 with rs1=31 -> op_a stays 0.
- Stall refresh: load op_a_addr=4/op_a=0x10, then stall=1 for 3 cycles with wb_en=1, wb_addr=4, wb_data=0x99 in cycle 2 -> op_a=0x99 from cycle 3 on, out_valid stays 1, op_b unchanged.
- Flush vs stall: stall=1 and flush=1 together with in_valid=1 -> out_valid=0 and op_a=op_b=0 next cycle. Then release both with in_valid=1 -> a normal load resumes in 1 cycle.
- Dual match: rs1=rs2=9, wb_en=1, wb_addr=9, wb_data=0x5A5A -> op_a=op_b=0x5A5A.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file operand path.
package regfile_pkg;
  localparam int WIDTH    = 64;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int ZERO_REG = 31;

  typedef logic [WIDTH-1:0] reg_data_t;
  typedef logic [AW-1:0]    reg_addr_t;
endpackage

// File: rtl/operand_bypass.sv
// Per-port operand select: XZR forces zero, then same-cycle write-back bypass, then register-file data.
module operand_bypass
  import regfile_pkg::*;
(
  input  reg_addr_t rs_addr,
  input  reg_data_t rd_data,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_data_t wb_data,
  output reg_data_t operand
);

  always_comb begin
    operand = rd_data;
    if (rs_addr == reg_addr_t'(ZERO_REG)) begin
      operand = '0;
    end else if (wb_en && (wb_addr == rs_addr)) begin
      // The register file only sees this write at the next edge.
      operand = wb_data;
    end
  end

endmodule

// File: rtl/regfile_operand_stage.sv
// ID/EX operand register with XZR/bypass select; flush > stall > load, and held operands
// track write-backs while stalled so EX never sees a stale value.
module regfile_operand_stage
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      in_valid,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  reg_data_t rd_data1,
  input  reg_data_t rd_data2,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_data_t wb_data,
  input  logic      stall,
  input  logic      flush,
  output reg_data_t op_a,
  output reg_data_t op_b,
  output reg_addr_t op_a_addr,
  output reg_addr_t op_b_addr,
  output logic      out_valid
);

  reg_data_t sel_a;
  reg_data_t sel_b;
  logic      refresh_a;
  logic      refresh_b;

  operand_bypass u_bypass_a (
    .rs_addr (rs1_addr),
    .rd_data (rd_data1),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .operand (sel_a)
  );

  operand_bypass u_bypass_b (
    .rs_addr (rs2_addr),
    .rd_data (rd_data2),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .operand (sel_b)
  );

  // Only a live, non-XZR held operand may pick up a later write-back.
  assign refresh_a = wb_en && (wb_addr == op_a_addr) &&
                     (op_a_addr != reg_addr_t'(ZERO_REG)) && out_valid;
  assign refresh_b = wb_en && (wb_addr == op_b_addr) &&
                     (op_b_addr != reg_addr_t'(ZERO_REG)) && out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_a_addr <= '0;
      op_b_addr <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      op_a      <= '0;
      op_b      <= '0;
      op_a_addr <= '0;
      op_b_addr <= '0;
      out_valid <= 1'b0;
    end else if (stall) begin
      if (refresh_a) op_a <= wb_data;
      if (refresh_b) op_b <= wb_data;
    end else begin
      op_a      <= sel_a;
      op_b      <= sel_b;
      op_a_addr <= rs1_addr;
      op_b_addr <= rs2_addr;
      out_valid <= in_valid;
    end
  end

endmodule
